// File: rtl/sig_capture_pkg.sv
// Shared types and encodings for the triggered waveform capture stage.
package sig_capture_pkg;

  // Capture sequence: fill pre-trigger history, hunt for the crossing,
  // collect post-trigger samples, then stream the buffer out.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } state_t;

  // Trigger edge selection as seen on the trig_edge input.
  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

endpackage

// File: rtl/sig_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The read register only updates when re_i is high, so the last read word
// stays on rdata_o while the downstream output register is stalled.
module sig_capture_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store a sample when the capture FSM asks for it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: one-cycle synchronous read, held while re_i is low.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_capture.sv
// Triggered capture of the sine generator output: keeps PRE_TRIG samples
// before a level crossing and DEPTH-PRE_TRIG from it onwards, then streams
// the whole buffer out oldest-first over a valid/ready interface.
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int PRE_TRIG   = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_edge,
  output logic                  busy,
  output logic                  triggered,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  // Counters must reach DEPTH itself (readout issue count), hence one extra bit.
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int POST_N = DEPTH - PRE_TRIG;

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_N - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;        // fill / post sample count
  logic [CNT_W-1:0]        iss_cnt_q, iss_cnt_d; // RAM reads issued
  logic [CNT_W-1:0]        ld_cnt_q, ld_cnt_d;   // samples loaded into dout
  logic                    ram_vld_q, ram_vld_d; // RAM read register holds an unconsumed sample
  logic [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic                    trig_q, trig_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;

  logic                    ram_we;
  logic                    ram_re;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    load;
  logic                    xfer;

  // Crossing test; equality only counts on the new-sample side.
  function automatic logic trig_hit(input logic [DATA_WIDTH-1:0] p,
                                    input logic [DATA_WIDTH-1:0] d,
                                    input logic [DATA_WIDTH-1:0] lvl,
                                    input logic                  e);
    logic rising;
    logic falling;
    rising  = (e == TRIG_RISING)  && (p < lvl) && (d >= lvl);
    falling = (e == TRIG_FALLING) && (p > lvl) && (d <= lvl);
    return rising | falling;
  endfunction

  sig_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state, pointer, counter and readout pipeline control.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    iss_cnt_d = iss_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    ram_vld_d = ram_vld_q;
    prev_d    = prev_q;
    trig_d    = trig_q;
    dout_d    = dout_q;
    vld_d     = vld_q;
    last_d    = last_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    // The output register can take a new sample when it is empty or draining.
    xfer = vld_q && dout_ready;
    load = ram_vld_q && (!vld_q || dout_ready);

    if (en && (state_q != READOUT)) begin
      prev_d = din;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arm) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (en) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ARMED: begin
        if (en) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig_hit(prev_q, din, trig_level, trig_edge)) begin
            trig_d = 1'b1;
            // The trigger sample is already post sample #1.
            if (POST_N == 1) begin
              cnt_d    = '0;
              rd_ptr_d = wr_ptr_q + 1'b1;
              state_d  = READOUT;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = POST;
            end
          end
        end
      end

      POST: begin
        if (en) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_q == POST_LAST) begin
            cnt_d     = '0;
            iss_cnt_d = '0;
            ld_cnt_d  = '0;
            // Slot after the newest sample is the oldest one still kept.
            rd_ptr_d  = wr_ptr_q + 1'b1;
            state_d   = READOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      READOUT: begin
        // Only read when the RAM register will be free next cycle.
        ram_re = (iss_cnt_q != DEPTH_CNT) && (!ram_vld_q || load);
        if (ram_re) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          iss_cnt_d = iss_cnt_q + 1'b1;
          ram_vld_d = 1'b1;
        end else if (load) begin
          ram_vld_d = 1'b0;
        end

        if (load) begin
          dout_d   = ram_rdata;
          vld_d    = 1'b1;
          last_d   = (ld_cnt_q == DEPTH_LAST);
          ld_cnt_d = ld_cnt_q + 1'b1;
        end else if (xfer) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
        end

        if (xfer && last_q) begin
          state_d   = IDLE;
          trig_d    = 1'b0;
          vld_d     = 1'b0;
          last_d    = 1'b0;
          ram_vld_d = 1'b0;
          iss_cnt_d = '0;
          ld_cnt_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything but the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      iss_cnt_q <= '0;
      ld_cnt_q  <= '0;
      ram_vld_q <= 1'b0;
      prev_q    <= '0;
      trig_q    <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      iss_cnt_q <= iss_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      ram_vld_q <= ram_vld_d;
      prev_q    <= prev_d;
      trig_q    <= trig_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign triggered  = trig_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign dout_last  = last_q;

endmodule

// File: tb/tb_sig_capture.sv
// Scoreboard bench for sig_capture: the expected capture is derived from the
// sample sequence alone (find first crossing, take the surrounding window).
module tb_sig_capture;

  localparam int DW     = 8;
  localparam int DEPTH  = 256;
  localparam int PRE    = 64;
  localparam int POST_N = DEPTH - PRE;
  localparam int NS     = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_edge = 1'b0;
  logic          busy;
  logic          triggered;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t   q[$];
  logic [DW-1:0] s [NS];

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;

  sig_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .busy       (busy),
    .triggered  (triggered),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First sample index (counted from arm) that crosses the level once armed.
  function automatic int find_trig(input logic [DW-1:0] lvl, input logic edg);
    for (int i = PRE; i + POST_N <= NS; i++) begin
      if (edg == 1'b0 && s[i-1] < lvl && s[i] >= lvl) return i;
      if (edg == 1'b1 && s[i-1] > lvl && s[i] <= lvl) return i;
    end
    return -1;
  endfunction

  // Consumer side: ready pattern per test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ~dout_ready;
        default: dout_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: compare each transfer with the scoreboard, check stall stability.
  initial begin
    logic          held;
    logic [DW-1:0] hd;
    logic          hl;
    exp_t          e;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(dout_valid), 32'd1);
          chk("hold_data", 32'(dout), 32'(hd));
          chk("hold_last", 32'(dout_last), 32'(hl));
        end
        if (dout_valid && dout_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rd_data", 32'(dout), 32'(e.d));
            chk("rd_last", 32'(dout_last), 32'(e.l));
          end
          xfer_cnt++;
        end
        held = dout_valid && !dout_ready;
        hd   = dout;
        hl   = dout_last;
      end
    end
  end

  // One capture: arm, feed samples with the given en spacing, then drain.
  task automatic run_capture(input logic [DW-1:0] lvl, input logic edg, input int en_per,
                             input bit arm_post, input int rst_at);
    int t;
    int idx;
    int cyc;
    int w;
    bit did_rst;
    exp_t e;
    t = find_trig(lvl, edg);
    if (t < 0) begin
      chk("model_no_trigger", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < DEPTH; k++) begin
      e.d = s[t - PRE + k];
      e.l = (k == DEPTH - 1);
      q.push_back(e);
    end
    xfer_cnt = 0;
    trig_level = lvl;
    trig_edge  = edg;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < t + POST_N) begin
      en  = (cyc % en_per) == 0;
      din = s[idx];
      arm = arm_post && (idx == t + 10);
      if (idx == t) begin
        chk("armed_busy", 32'(busy), 32'd1);
        chk("armed_not_trig", 32'(triggered), 32'd0);
      end
      if (idx == t + 1) chk("post_triggered", 32'(triggered), 32'd1);
      @(posedge clk);
      if (en) idx++;
      #1;
      cyc++;
    end
    en  = 1'b0;
    arm = 1'b0;
    // Just entered readout: first valid lands two clocks later.
    chk("lat_c0", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_c1", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_c2", 32'(dout_valid), 32'd1);
    w = 0;
    did_rst = 1'b0;
    while (busy && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
      if (rst_at >= 0 && !did_rst && xfer_cnt >= rst_at) begin
        did_rst = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    chk("done_in_time", 32'(busy), 32'd0);
    if (rst_at < 0) chk("all_xfers", 32'(xfer_cnt), 32'(DEPTH));
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("idle_trig", 32'(triggered), 32'd0);
    chk("idle_valid", 32'(dout_valid), 32'd0);
    q.delete();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NS; i++) s[i] = DW'(i);
  endtask

  initial begin
    int tr;
    logic [DW-1:0] lvl;
    logic edg;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_trig", 32'(triggered), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_last", 32'(dout_last), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp, rising through 0x80.
    fill_ramp();
    ready_mode = 0;
    run_capture(8'h80, 1'b0, 1, 1'b0, -1);
    // Ramp, falling through 0x10: only the 0xFF->0x00 wrap qualifies.
    run_capture(8'h10, 1'b1, 1, 1'b0, -1);
    // Consumer toggling ready.
    ready_mode = 1;
    run_capture(8'h80, 1'b0, 1, 1'b0, -1);
    // Sparse en and a stray arm during the post phase.
    ready_mode = 0;
    run_capture(8'h80, 1'b0, 4, 1'b1, -1);
    // Flat signal at the level never crosses until it dips and comes back.
    for (int i = 0; i < NS; i++) s[i] = (i < 200) ? 8'h80 : (i == 200) ? 8'h00 : 8'h90;
    run_capture(8'h80, 1'b0, 1, 1'b0, -1);
    // Reset in the middle of readout, then a clean capture.
    fill_ramp();
    run_capture(8'h80, 1'b0, 1, 1'b0, 100);
    run_capture(8'h80, 1'b0, 1, 1'b0, -1);
    // Random waveforms, levels, edges, en density and backpressure.
    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      tr = -1;
      lvl = '0;
      edg = 1'b0;
      while (tr < 0) begin
        for (int i = 0; i < NS; i++) s[i] = DW'($urandom % 256);
        lvl = DW'($urandom_range(1, 254));
        edg = 1'($urandom % 2);
        tr  = find_trig(lvl, edg);
      end
      run_capture(lvl, edg, $urandom_range(1, 3), 1'($urandom % 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
